// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side feeder.
//   - DATA_BITS_DEF : default byte width, must match the transmitter
//   - tx_state_e    : issue-FSM state encoding (IDLE / ISSUE / WAIT_DONE)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock byte FIFO with a separate level counter.
// Ports:
//   clk_in, nrst_in   : clock, synchronous active-low reset
//   wr_en_in/wr_data_in : write strobe and data (dropped when full)
//   pop_in            : advance the read pointer (ignored when empty)
//   rd_data_out       : mem[rd_ptr], combinational view of the head entry
//   full_out/empty_out/level_out : registered occupancy flags and count
//   overflow_out      : one-cycle pulse for each write dropped while full
// ---------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DATA_BITS = DATA_BITS_DEF,
    localparam int AW       = $clog2(DEPTH),
    localparam int LW       = AW + 1
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    input  logic                 wr_en_in,
    input  logic [DATA_BITS-1:0] wr_data_in,
    input  logic                 pop_in,
    output logic [DATA_BITS-1:0] rd_data_out,
    output logic                 full_out,
    output logic                 empty_out,
    output logic [LW-1:0]        level_out,
    output logic                 overflow_out
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_overflow;

    logic                 w_wr_ok;
    logic                 w_pop_ok;
    logic [LW-1:0]        w_level_nxt;

    // Acceptance uses the registered full flag, so a pop in the same
    // cycle never frees room for a write that arrives while full.
    assign w_wr_ok  = wr_en_in & ~r_full;
    assign w_pop_ok = pop_in & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_ok, w_pop_ok})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk_in) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LW'(DEPTH));
            r_empty    <= (w_level_nxt == '0);
            r_overflow <= wr_en_in & r_full;
        end
    end

    assign rd_data_out  = r_mem[r_rd_ptr];
    assign full_out     = r_full;
    assign empty_out    = r_empty;
    assign level_out    = r_level;
    assign overflow_out = r_overflow;

endmodule : uart_sync_fifo

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Buffers host bytes and offers them one at a time to the UART transmitter,
// pacing issue with the transmitter's busy/done handshake.
// Ports:
//   clk_in, nrst_in          : shared oversampled baud clock, sync active-low reset
//   wr_en_in, wr_data_in     : host write port
//   full_out, empty_out, level_out, overflow_out : FIFO status
//   tx_data_out, data_rdy_out : byte offer to the transmitter
//   tx_busy_in, tx_done_in   : transmitter busy level and done pulse
// ---------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                     clk_in,
    input  logic                     nrst_in,
    input  logic                     wr_en_in,
    input  logic [DATA_BITS-1:0]     wr_data_in,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   level_out,
    output logic                     overflow_out,
    output logic [DATA_BITS-1:0]     tx_data_out,
    output logic                     data_rdy_out,
    input  logic                     tx_busy_in,
    input  logic                     tx_done_in
);

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_data_rdy;

    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_empty;
    logic                 w_pop;

    // Busy is only meaningful while an offer is outstanding; elsewhere it
    // is ignored so a lingering busy cannot pop a second entry.
    assign w_pop = (r_state == ST_ISSUE) & tx_busy_in;

    uart_sync_fifo #(
        .DEPTH     (DEPTH),
        .DATA_BITS (DATA_BITS)
    ) u_fifo (
        .clk_in       (clk_in),
        .nrst_in      (nrst_in),
        .wr_en_in     (wr_en_in),
        .wr_data_in   (wr_data_in),
        .pop_in       (w_pop),
        .rd_data_out  (w_rd_data),
        .full_out     (full_out),
        .empty_out    (w_empty),
        .level_out    (level_out),
        .overflow_out (overflow_out)
    );

    // IDLE always lasts at least one cycle after WAIT_DONE, which gives the
    // transmitter time to drop busy before the next offer is raised.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            r_state    <= ST_IDLE;
            r_tx_data  <= '0;
            r_data_rdy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_data_rdy <= 1'b0;
                    if (!w_empty) begin
                        r_tx_data  <= w_rd_data;
                        r_data_rdy <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (tx_busy_in) begin
                        r_data_rdy <= 1'b0;
                        r_state    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    r_data_rdy <= 1'b0;
                    if (tx_done_in) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_data_rdy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign empty_out    = w_empty;
    assign tx_data_out  = r_tx_data;
    assign data_rdy_out = r_data_rdy;

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
// Directed bench for uart_tx_feeder with a small behavioural transmitter.
// The transmitter model can be switched off so busy/done are hand-driven.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int DB    = 8;
    localparam int OVS   = 4;
    localparam int FRAME = 10 * OVS;

    logic          clk;
    logic          nrst;
    logic          wr_en;
    logic [DB-1:0] wr_data;
    logic          full;
    logic          empty;
    logic [4:0]    level;
    logic          overflow;
    logic [DB-1:0] tx_data;
    logic          data_rdy;
    logic          tx_busy;
    logic          tx_done;

    logic          model_en;
    logic          man_busy;
    logic          man_done;
    logic          m_busy;
    logic          m_done;
    int            m_cnt;
    logic [DB-1:0] cap [$];

    int checks = 0;
    int errors = 0;

    uart_tx_feeder #(.DEPTH(DEPTH), .DATA_BITS(DB)) dut (
        .clk_in       (clk),
        .nrst_in      (nrst),
        .wr_en_in     (wr_en),
        .wr_data_in   (wr_data),
        .full_out     (full),
        .empty_out    (empty),
        .level_out    (level),
        .overflow_out (overflow),
        .tx_data_out  (tx_data),
        .data_rdy_out (data_rdy),
        .tx_busy_in   (tx_busy),
        .tx_done_in   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = model_en ? m_busy : man_busy;
    assign tx_done = model_en ? m_done : man_done;

    // Transmitter: latches the offered byte when idle, stays busy for one
    // frame, then pulses done.
    always @(posedge clk) begin
        if (!nrst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_cnt == FRAME - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (model_en && data_rdy) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                cap.push_back(tx_data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset;
        wr_en = 1'b1; wr_data = 8'h99;
        do_reset();
        wr_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL reset_flags: empty=%b full=%b level=%0d, want 1 0 0", empty, full, level);
        end
        checks++;
        if (data_rdy !== 1'b0 || tx_data !== 8'h00 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b data=%h ovf=%b, want 0 00 0", data_rdy, tx_data, overflow);
        end
    endtask

    task automatic test_single;
        model_en = 1'b1;
        cap.delete();
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        checks++;
        if (empty !== 1'b0 || level !== 5'd1 || data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL single_k: empty=%b level=%0d rdy=%b, want 0 1 0", empty, level, data_rdy);
        end
        tick();
        checks++;
        if (data_rdy !== 1'b1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_offer: rdy=%b data=%h, want 1 a5", data_rdy, tx_data);
        end
        tick();
        checks++;
        if (tx_busy !== 1'b1 || data_rdy !== 1'b1 || level !== 5'd1) begin
            errors++;
            $display("FAIL single_busy: busy=%b rdy=%b level=%0d, want 1 1 1", tx_busy, data_rdy, level);
        end
        tick();
        checks++;
        if (data_rdy !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: rdy=%b level=%0d empty=%b, want 0 0 1", data_rdy, level, empty);
        end
        for (int i = 0; i < 200 && !m_done; i++) tick();
        tick(); tick();
        checks++;
        if (cap.size() != 1 || cap[0] !== 8'hA5 || data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL single_tx: count=%0d rdy=%b, want 1 byte a5, rdy 0", cap.size(), data_rdy);
        end
    endtask

    task automatic test_burst;
        model_en = 1'b0; man_busy = 1'b0; man_done = 1'b0;
        do_reset();
        cap.delete();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        checks++;
        if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL burst_full: full=%b level=%0d ovf=%b, want 1 16 0", full, level, overflow);
        end
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            errors++;
            $display("FAIL burst_ovf: ovf=%b level=%0d, want 1 16", overflow, level);
        end
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL burst_ovf_width: ovf=%b, want 0", overflow);
        end
        model_en = 1'b1;
        for (int i = 0; i < 2000 && cap.size() < 16; i++) tick();
        for (int i = 0; i < 60; i++) tick();
        checks++;
        if (cap.size() != 16) begin
            errors++;
            $display("FAIL burst_count: got %0d bytes, want 16", cap.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL burst_order[%0d]: got %h, want %h", i, cap[i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (empty !== 1'b1 || level !== 5'd0) begin
            errors++;
            $display("FAIL burst_end: empty=%b level=%0d, want 1 0", empty, level);
        end
    endtask

    task automatic test_full_pop;
        model_en = 1'b0; man_busy = 1'b0; man_done = 1'b0;
        do_reset();
        cap.delete();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            tick();
        end
        // Pop and write land on the same edge while full.
        man_busy = 1'b1; wr_data = 8'hEE;
        tick();
        man_busy = 1'b0; wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 5'd15 || full !== 1'b0) begin
            errors++;
            $display("FAIL fullpop: ovf=%b level=%0d full=%b, want 1 15 0", overflow, level, full);
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        model_en = 1'b1;
        for (int i = 0; i < 2000 && cap.size() < 15; i++) tick();
        for (int i = 0; i < 60; i++) tick();
        checks++;
        if (cap.size() != 15) begin
            errors++;
            $display("FAIL fullpop_count: got %0d bytes, want 15", cap.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (cap[i] !== 8'h21 + 8'(i)) begin
                    errors++;
                    $display("FAIL fullpop_order[%0d]: got %h, want %h", i, cap[i], 8'h21 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_wait_done_write;
        model_en = 1'b0; man_busy = 1'b0; man_done = 1'b0;
        do_reset();
        wr_en = 1'b1; wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        tick();
        man_busy = 1'b1;
        tick();
        man_busy = 1'b0;
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        checks++;
        if (data_rdy !== 1'b0 || level !== 5'd1) begin
            errors++;
            $display("FAIL wd_buffered: rdy=%b level=%0d, want 0 1", data_rdy, level);
        end
        tick(); tick(); tick();
        checks++;
        if (data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL wd_hold: rdy=%b, want 0", data_rdy);
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        checks++;
        if (data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle_dwell: rdy=%b, want 0", data_rdy);
        end
        tick();
        checks++;
        if (data_rdy !== 1'b1 || tx_data !== 8'h3C || level !== 5'd1) begin
            errors++;
            $display("FAIL wd_offer: rdy=%b data=%h level=%0d, want 1 3c 1", data_rdy, tx_data, level);
        end
    endtask

    task automatic test_reset_mid;
        model_en = 1'b0; man_busy = 1'b0; man_done = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h61 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        man_busy = 1'b1;
        tick();
        man_busy = 1'b0;
        checks++;
        if (level !== 5'd5 || data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_setup: level=%0d rdy=%b, want 5 0", level, data_rdy);
        end
        do_reset();
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_cleared: level=%0d empty=%b rdy=%b, want 0 1 0", level, empty, data_rdy);
        end
        cap.delete();
        model_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 200 && cap.size() < 1; i++) tick();
        for (int i = 0; i < FRAME + 20; i++) tick();
        checks++;
        if (cap.size() != 1 || cap[0] !== 8'h5A) begin
            errors++;
            $display("FAIL rmid_tx: count=%0d, want exactly one byte 5a", cap.size());
        end
    endtask

    task automatic test_spurious;
        model_en = 1'b0; man_busy = 1'b0; man_done = 1'b0;
        do_reset();
        man_busy = 1'b1; man_done = 1'b1;
        tick();
        man_busy = 1'b0; man_done = 1'b0;
        tick();
        checks++;
        if (level !== 5'd0 || data_rdy !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL spur_idle_empty: level=%0d rdy=%b empty=%b, want 0 0 1", level, data_rdy, empty);
        end
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_data = 8'h78;
        tick();
        wr_en = 1'b0;
        checks++;
        if (data_rdy !== 1'b1 || tx_data !== 8'h77 || level !== 5'd2) begin
            errors++;
            $display("FAIL spur_offer1: rdy=%b data=%h level=%0d, want 1 77 2", data_rdy, tx_data, level);
        end
        man_busy = 1'b1;
        tick();
        tick(); tick(); tick();
        man_busy = 1'b0;
        checks++;
        if (level !== 5'd1 || data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL spur_busy_wd: level=%0d rdy=%b, want 1 0", level, data_rdy);
        end
        man_done = 1'b1;
        tick();
        tick();
        man_done = 1'b0;
        tick();
        checks++;
        if (level !== 5'd1 || data_rdy !== 1'b1 || tx_data !== 8'h78) begin
            errors++;
            $display("FAIL spur_done_idle: level=%0d rdy=%b data=%h, want 1 1 78", level, data_rdy, tx_data);
        end
    endtask

    initial begin
        nrst = 1'b1; wr_en = 1'b0; wr_data = '0;
        model_en = 1'b0; man_busy = 1'b0; man_done = 1'b0;
        tick();
        test_reset();
        test_single();
        test_burst();
        test_full_pop();
        test_wait_done_write();
        test_reset_mid();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_feeder
